// File: rtl/mdu_pkg.sv
// MDU shared definitions: op encodings, FSM states, iteration constants and
// a small magnitude helper used by the sign fix-up.
package mdu_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [5:0]  ITER_CNT      = 6'd32;

    // Absolute value of a 32-bit operand when its sign is to be honoured.
    function automatic logic [31:0] mag(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mdu_div_iter.sv
// Restoring divider datapath on unsigned magnitudes. The quotient register
// starts out holding the dividend: dividend bits shift out of the top while
// quotient bits shift in at the bottom, one bit per step.
module mdu_div_iter (
    input  logic        clk,
    input  logic        resetn,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quot,
    output logic [31:0] rem
);
    logic [31:0] dsr;
    logic [32:0] shifted;
    logic [32:0] diff;

    assign shifted = {rem, quot[31]};
    assign diff    = shifted - {1'b0, dsr};

    // Load operands, then trial-subtract and restore on a negative difference.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rem  <= '0;
            quot <= '0;
            dsr  <= '0;
        end else if (load) begin
            rem  <= '0;
            quot <= dividend;
            dsr  <= divisor;
        end else if (step) begin
            quot <= {quot[30:0], ~diff[32]};
            rem  <= diff[32] ? shifted[31:0] : diff[31:0];
        end
    end
endmodule

// File: rtl/mdu.sv
// Multiply/divide unit with architectural HI/LO. Iterative shift-add multiply
// and restoring divide, one bit per cycle. Defining MDU_FAST_MULT_EN turns
// MULT/MULTU into a single-step operation; divide is unaffected.
module mdu
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    state_e      state;
    logic [5:0]  cnt;
    logic        is_div;
    logic        neg_p;
    logic        neg_r;
    logic        b_zero;
    logic [31:0] a_r;
    logic [31:0] mc;
    logic [63:0] prod;
    logic        done_r;

    logic        sgn, sa, sb;
    logic [31:0] ma, mb;
    logic [32:0] msum;
    logic [31:0] quot, rem;
    logic [31:0] res_hi, res_lo;
    logic        accept;

    assign sgn    = ~op[0];
    assign sa     = sgn & a[31];
    assign sb     = sgn & b[31];
    assign ma     = mag(a, sa);
    assign mb     = mag(b, sb);
    assign accept = (state == S_IDLE) & start & ~flush;

    assign stall  = ((state == S_IDLE) & start) | (state == S_CALC);
    // A flush in DONE cancels the commit, so the pulse is withdrawn with it.
    assign done   = done_r & ~flush;

    // One shift-add step: add multiplicand into the upper half on a set LSB.
    assign msum   = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, mc} : 33'd0);

    mdu_div_iter u_div (
        .clk      (clk),
        .resetn   (resetn),
        .load     (accept & op[1]),
        .step     ((state == S_CALC) & is_div),
        .dividend (ma),
        .divisor  (mb),
        .quot     (quot),
        .rem      (rem)
    );

    // Sign fix-up of the magnitude result; divide-by-zero is special-cased.
    always_comb begin
        res_hi = prod[63:32];
        res_lo = prod[31:0];
        if (is_div) begin
            if (b_zero) begin
                res_hi = a_r;
                res_lo = DIV_BY_ZERO_Q;
            end else begin
                res_lo = neg_p ? (~quot + 32'd1) : quot;
                res_hi = neg_r ? (~rem + 32'd1) : rem;
            end
        end else if (neg_p) begin
            {res_hi, res_lo} = ~prod + 64'd1;
        end
    end

    // Control FSM plus multiply datapath and HI/LO registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= S_IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_p  <= 1'b0;
            neg_r  <= 1'b0;
            b_zero <= 1'b0;
            a_r    <= '0;
            mc     <= '0;
            prod   <= '0;
            done_r <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (mthi) hi <= wdata;
                    if (mtlo) lo <= wdata;
                    if (accept) begin
                        is_div <= op[1];
                        neg_p  <= sa ^ sb;
                        neg_r  <= sa;
                        b_zero <= (b == 32'd0);
                        a_r    <= a;
                        cnt    <= ITER_CNT;
                        mc     <= ma;
                        prod   <= {32'd0, mb};
                        state  <= S_CALC;
`ifdef MDU_FAST_MULT_EN
                        if (!op[1]) begin
                            prod   <= {32'd0, ma} * {32'd0, mb};
                            state  <= S_DONE;
                            done_r <= 1'b1;
                        end
`endif
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - 6'd1;
                        if (!is_div) prod <= {msum, prod[31:1]};
                        if (cnt == 6'd1) begin
                            state  <= S_DONE;
                            done_r <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    done_r <= 1'b0;
                    state  <= S_IDLE;
                    if (!flush) begin
                        hi <= res_hi;
                        lo <= res_lo;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: a cycle-level behavioural model (busy/done
// phases plus plain 64-bit arithmetic for results) is compared every cycle,
// with directed literal checks for the corner cases and a random soak.
module tb_mdu;
    logic        clk = 0;
    logic        resetn;
    logic        start, flush, mthi, mtlo;
    logic [1:0]  op;
    logic [31:0] a, b, wdata;
    logic        stall, done;
    logic [31:0] hi, lo;

    int vec = 0;
    int miss = 0;
    int ncyc = 0;

    // model state
    int          ph;      // 0 idle, 1 busy, 2 result-commit cycle
    int          left;
    logic [63:0] pend;
    logic [31:0] m_hi, m_lo;
    logic        sdone;

`ifdef MDU_FAST_MULT_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    mdu dut (
        .clk(clk), .resetn(resetn), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .stall(stall), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] golden(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy;
        int ix, iy;
        logic [63:0] ux, uy;
        case (o)
            2'b00: begin sx = $signed(x); sy = $signed(y); return 64'(sx * sy); end
            2'b01: begin ux = {32'd0, x}; uy = {32'd0, y}; return ux * uy; end
            2'b10: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                ix = $signed(x); iy = $signed(y);
                return {32'(ix % iy), 32'(ix / iy)};
            end
            default: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s @cycle %0d: got %h want %h", nm, ncyc, act, exp);
        end
    endtask

    task automatic model_reset();
        ph = 0; left = 0; m_hi = 0; m_lo = 0; pend = 0;
    endtask

    // One clock: drive at negedge, compare mid-cycle, advance the model.
    task automatic cyc(input logic s, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic f, input logic mh, input logic ml, input logic [31:0] wd);
        logic e_stall, e_done;
        start = s; op = o; a = x; b = y; flush = f; mthi = mh; mtlo = ml; wdata = wd;
        e_stall = (ph == 0 && s) || ph == 1;
        e_done  = (ph == 2) && !f;
        #2;
        sdone = done;
        chk("stall", 64'(stall), 64'(e_stall));
        chk("done",  64'(done),  64'(e_done));
        chk("hi",    64'(hi),    64'(m_hi));
        chk("lo",    64'(lo),    64'(m_lo));
        case (ph)
            0: begin
                if (mh) m_hi = wd;
                if (ml) m_lo = wd;
                if (s && !f) begin
                    pend = golden(o, x, y);
`ifdef MDU_FAST_MULT_EN
                    if (!o[1]) ph = 2; else begin ph = 1; left = 32; end
`else
                    ph = 1; left = 32;
`endif
                end
            end
            1: begin
                if (f) ph = 0;
                else begin left--; if (left == 0) ph = 2; end
            end
            default: begin
                if (!f) {m_hi, m_lo} = pend;
                ph = 0;
            end
        endcase
        @(negedge clk);
        ncyc++;
    endtask

    task automatic idle();
        cyc(0, 2'b00, 32'd0, 32'd0, 0, 0, 0, 32'd0);
    endtask

    // Issue one op and wait (bounded) for done; returns cycles from start.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, output int lat);
        cyc(1, o, x, y, 0, 0, 0, 32'd0);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            idle();
            if (sdone) begin lat = k; break; end
        end
    endtask

    function automatic logic [31:0] rnd_opnd();
        logic [31:0] c [5];
        c[0] = 32'd0; c[1] = 32'd1; c[2] = 32'hFFFF_FFFF; c[3] = 32'h8000_0000; c[4] = 32'h7FFF_FFFF;
        if ($urandom_range(3) == 0) return c[$urandom_range(4)];
        if ($urandom_range(3) == 0) return $urandom_range(20) - 10;
        return $urandom;
    endfunction

    initial begin
        int lat, ndone;
        resetn = 0; start = 0; flush = 0; mthi = 0; mtlo = 0; op = 0; a = 0; b = 0; wdata = 0;
        model_reset();
        #1;
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        repeat (2) @(negedge clk);
        resetn = 1;

        // pin the model itself
        chk("gold_multu", golden(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
        chk("gold_mult",  golden(2'b00, -32'sd3, 32'd7), 64'hFFFF_FFFF_FFFF_FFEB);
        chk("gold_div",   golden(2'b10, -32'sd7, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        chk("multu_lat", 64'(lat), 64'(MUL_LAT));
        chk("multu_hi", 64'(hi), 64'hFFFF_FFFE);
        chk("multu_lo", 64'(lo), 64'h0000_0001);

        run_op(2'b00, -32'sd3, 32'd7, lat);
        chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("mult_lo", 64'(lo), 64'hFFFF_FFEB);

        run_op(2'b10, -32'sd7, 32'd2, lat);
        chk("div_lat", 64'(lat), 64'd33);
        chk("div_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("div_lo", 64'(lo), 64'hFFFF_FFFD);

        run_op(2'b11, 32'd100, 32'd0, lat);
        chk("dz_lat", 64'(lat), 64'd33);
        chk("dz_hi", 64'(hi), 64'd100);
        chk("dz_lo", 64'(lo), 64'hFFFF_FFFF);

        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        chk("ovf_hi", 64'(hi), 64'd0);
        chk("ovf_lo", 64'(lo), 64'h8000_0000);

        // flush at cycle 10 of a DIVU
        cyc(1, 2'b11, 32'd100, 32'd7, 0, 0, 0, 32'd0);
        repeat (9) idle();
        cyc(0, 2'b00, 32'd0, 32'd0, 1, 0, 0, 32'd0);
        #2;
        chk("flush_idle_stall", 64'(stall), 64'd0);
        chk("flush_hi", 64'(hi), 64'd0);
        chk("flush_lo", 64'(lo), 64'h8000_0000);
        @(negedge clk);
        ncyc = ncyc;
        ndone = 0;
        for (int k = 0; k < 30; k++) begin idle(); if (sdone) ndone++; end
        chk("flush_nodone", 64'(ndone), 64'd0);

        // start is rejected when flushed in the same idle cycle
        cyc(1, 2'b11, 32'd9, 32'd3, 1, 0, 0, 32'd0);
        idle();
        chk("flush_rej_stall", 64'(stall), 64'd0);

        // register write and start in the same cycle: write lands, result overwrites
        cyc(1, 2'b11, 32'd50, 32'd5, 0, 0, 1, 32'h0000_ABCD);
        chk("mtlo_start", 64'(lo), 64'h0000_ABCD);
        cyc(0, 2'b00, 32'd0, 32'd0, 0, 1, 1, 32'h5555_5555);  // ignored while busy
        for (int k = 0; k < 40 && !sdone; k++) idle();
        idle();
        chk("mtlo_start_res", 64'(lo), 64'd10);

        // reset in the middle of a MULT
        cyc(1, 2'b00, 32'd12345, 32'd678, 0, 0, 0, 32'd0);
        repeat (4) idle();
        start = 0; flush = 0; mthi = 0; mtlo = 0;
        #1 resetn = 0;
        #1;
        chk("mid_rst_hi", 64'(hi), 64'd0);
        chk("mid_rst_lo", 64'(lo), 64'd0);
        chk("mid_rst_stall", 64'(stall), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        model_reset();
        @(negedge clk);
        resetn = 1;
        cyc(0, 2'b00, 32'd0, 32'd0, 0, 0, 1, 32'h0000_1234);
        chk("post_rst_mtlo", 64'(lo), 64'h0000_1234);
        run_op(2'b11, 32'd100, 32'd7, lat);
        chk("post_rst_lat", 64'(lat), 64'd33);
        chk("post_rst_lo", 64'(lo), 64'd14);
        chk("post_rst_hi", 64'(hi), 64'd2);

        // random soak
        for (int k = 0; k < 4000; k++) begin
            cyc($urandom_range(3) == 0, 2'($urandom_range(3)), rnd_opnd(), rnd_opnd(),
                $urandom_range(39) == 0, $urandom_range(9) == 0, $urandom_range(9) == 0, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
